// File: rtl/sfifo_write_arbiter_pkg.sv
// Shared types and helpers for the sync-FIFO write-port arbiter.
// Optional feature macro used by this block: SFIFO_ARB_ERR_EN.
package sfifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Usable FIFO capacity: one slot is sacrificed to tell full from empty.
    function automatic int calc_cap(input int depth_log2);
        return (1 << depth_log2) - 1;
    endfunction

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sfifo_write_arbiter_if.sv
// Requester / FIFO write-port bundle of the arbiter.
// master: arbiter side. slave: requesters, FIFO and consumer tap.
// With SFIFO_ARB_ERR_EN defined the bundle also carries the sticky o_ERR.
interface sfifo_write_arbiter_if
    import sfifo_arb_pkg::*;
#(
    parameter int p_NUM_REQ    = 4,
    parameter int p_DATA_WIDTH = 8,
    parameter int p_FIFO_DEPTH = 8
) ();

    localparam int GW = clog2(p_NUM_REQ);

    logic [p_NUM_REQ-1:0]              i_REQ_VALID;
    logic [p_NUM_REQ*p_DATA_WIDTH-1:0] i_REQ_DATA;
    logic [p_NUM_REQ-1:0]              o_REQ_READY;
    logic                              i_FIFO_READ;
    logic                              o_FIFO_WRITE;
    logic [p_DATA_WIDTH-1:0]           o_FIFO_DATA;
    logic [p_FIFO_DEPTH:0]             o_LEVEL;
    logic                              o_FULL;
    logic [GW-1:0]                     o_GRANT_ID;
`ifdef SFIFO_ARB_ERR_EN
    logic                              o_ERR;
`endif

    modport master (
        input  i_REQ_VALID, i_REQ_DATA, i_FIFO_READ,
        output o_REQ_READY, o_FIFO_WRITE, o_FIFO_DATA, o_LEVEL, o_FULL, o_GRANT_ID
`ifdef SFIFO_ARB_ERR_EN
        , output o_ERR
`endif
    );

    modport slave (
        output i_REQ_VALID, i_REQ_DATA, i_FIFO_READ,
        input  o_REQ_READY, o_FIFO_WRITE, o_FIFO_DATA, o_LEVEL, o_FULL, o_GRANT_ID
`ifdef SFIFO_ARB_ERR_EN
        , input o_ERR
`endif
    );

endinterface

// File: rtl/sfifo_write_arbiter_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// wrapping modulo p_NUM_REQ (last_i itself is checked last).
module rr_priority_pick #(
    parameter int p_NUM_REQ = 4,
    parameter int p_IDX_W   = 2
) (
    input  logic [p_NUM_REQ-1:0] req_i,
    input  logic [p_IDX_W-1:0]   last_i,
    output logic                 found_o,
    output logic [p_IDX_W-1:0]   idx_o
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [p_IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop; without it a
        // combinational block with conditional writes infers a latch.
        found_o = 1'b0;
        idx_o   = last_i;
        cand    = last_i;
        for (int off = p_NUM_REQ; off >= 1; off--) begin
            cand = p_IDX_W'((int'(last_i) + off) % p_NUM_REQ);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sfifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter in front of a sync FIFO write port.
// Tracks FIFO occupancy itself (accepted writes minus effective reads) so
// ready never depends on the FIFO's lagging flags and the FIFO never overflows.
// Optional: define SFIFO_ARB_ERR_EN to add the sticky underflow-read flag o_ERR.
module sfifo_write_arbiter
    import sfifo_arb_pkg::*;
#(
    parameter int p_NUM_REQ    = 4,
    parameter int p_DATA_WIDTH = 8,
    parameter int p_FIFO_DEPTH = 8,
    parameter int p_MAX_BURST  = 4
) (
    input logic                   i_CLK,
    input logic                   i_RESET,
    sfifo_write_arbiter_if.master bus
);

    localparam int GW = clog2(p_NUM_REQ);
    localparam int LW = p_FIFO_DEPTH + 1;
    localparam int BW = clog2(p_MAX_BURST + 1);
    localparam logic [LW-1:0] CAP       = LW'(calc_cap(p_FIFO_DEPTH));
    localparam logic [BW-1:0] MAX_BURST = BW'(p_MAX_BURST);

    arb_state_e              state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    full_q;
    logic                    wr_q;
    logic [p_DATA_WIDTH-1:0] data_q;

    logic                    pick_found;
    logic [GW-1:0]           pick_idx;
    logic [p_NUM_REQ-1:0]    ready;
    logic                    accept;
    logic                    rd_eff;
    logic [p_DATA_WIDTH-1:0] req_data [p_NUM_REQ];

    for (genvar k = 0; k < p_NUM_REQ; k++) begin : g_unpack
        assign req_data[k] = bus.i_REQ_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH];
    end

    rr_priority_pick #(
        .p_NUM_REQ (p_NUM_REQ),
        .p_IDX_W   (GW)
    ) u_pick (
        .req_i   (bus.i_REQ_VALID),
        .last_i  (grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Ready goes only to the granted requester, in BURST, while space remains.
    always_comb begin
        ready = '0;
        if (state_q == BURST && level_q < CAP) ready[grant_q] = 1'b1;
    end

    assign accept = |(bus.i_REQ_VALID & ready);
    // A read of an empty FIFO does nothing, so it must not move the level.
    assign rd_eff = bus.i_FIFO_READ && (level_q != '0);

    // Arbitration FSM: IDLE picks the next requester, BURST moves up to p_MAX_BURST beats.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    burst_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    burst_d = burst_q + BW'(1);
                    if (burst_d == MAX_BURST) state_d = IDLE;
                end else if (!bus.i_REQ_VALID[grant_q]) begin
                    // Valid-high with ready-low (full) stays here: no timeout.
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Occupancy: +1 on accept, -1 on effective read, unchanged on both or neither.
    always_comb begin
        level_d = level_q;
        if (accept && !rd_eff)      level_d = level_q + LW'(1);
        else if (!accept && rd_eff) level_d = level_q - LW'(1);
    end

    // State, occupancy and the registered FIFO write port.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= IDLE;
            grant_q <= GW'(p_NUM_REQ - 1);
            burst_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            level_q <= level_d;
            full_q  <= (level_d == CAP);
            wr_q    <= accept;
            if (accept) data_q <= req_data[grant_q];
        end
    end

`ifdef SFIFO_ARB_ERR_EN
    logic err_q;

    // Sticky underflow flag: set by any read presented while the level is 0.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET)                                   err_q <= 1'b0;
        else if (bus.i_FIFO_READ && level_q == '0)     err_q <= 1'b1;
    end

    assign bus.o_ERR = err_q;
`endif

    assign bus.o_REQ_READY  = ready;
    assign bus.o_FIFO_WRITE = wr_q;
    assign bus.o_FIFO_DATA  = data_q;
    assign bus.o_LEVEL      = level_q;
    assign bus.o_FULL       = full_q;
    assign bus.o_GRANT_ID   = grant_q;

endmodule

// File: tb/tb_sfifo_write_arbiter.sv
// Directed self-checking bench for sfifo_write_arbiter.
// Two instances: default depth (CAP=255) and depth 3 (CAP=7) for the full case.
// Inputs change and outputs are sampled a few time units after the rising edge.
module tb_sfifo_write_arbiter;
    import sfifo_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    sfifo_write_arbiter_if #(.p_NUM_REQ(N), .p_DATA_WIDTH(W), .p_FIFO_DEPTH(8)) bus ();
    sfifo_write_arbiter_if #(.p_NUM_REQ(N), .p_DATA_WIDTH(W), .p_FIFO_DEPTH(3)) bus_s ();

    sfifo_write_arbiter #(
        .p_NUM_REQ(N), .p_DATA_WIDTH(W), .p_FIFO_DEPTH(8), .p_MAX_BURST(4)
    ) u_dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    sfifo_write_arbiter #(
        .p_NUM_REQ(N), .p_DATA_WIDTH(W), .p_FIFO_DEPTH(3), .p_MAX_BURST(4)
    ) u_dut_s (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_REQ_VALID   = '0;
        bus.i_FIFO_READ   = 1'b0;
        bus.i_REQ_DATA    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus_s.i_REQ_VALID = '0;
        bus_s.i_FIFO_READ = 1'b0;
        bus_s.i_REQ_DATA  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          exp_rdy;
        int          prev_rdy;
        int          prev_gnt;
        int          exp_level;
        logic [14:0] t2_mask;

        // ---------------- reset state + round robin over all four ----------------
        do_reset();
        #1;
        check("rst_ready", 32'(bus.o_REQ_READY), 0);
        check("rst_write", 32'(bus.o_FIFO_WRITE), 0);
        check("rst_data",  32'(bus.o_FIFO_DATA), 0);
        check("rst_level", 32'(bus.o_LEVEL), 0);
        check("rst_full",  32'(bus.o_FULL), 0);
        check("rst_grant", 32'(bus.o_GRANT_ID), 3);
`ifdef SFIFO_ARB_ERR_EN
        check("rst_err",   32'(bus.o_ERR), 0);
`endif
        bus.i_REQ_VALID = 4'hF;
        prev_rdy  = 0;
        prev_gnt  = 0;
        exp_level = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            // Cycle 0 of every 5 is the arbitration bubble; then 4 beats.
            exp_rdy = (c % 5 == 0) ? 0 : (1 << ((c / 5) % 4));
            check("rr_ready", 32'(bus.o_REQ_READY), exp_rdy);
            if (exp_rdy != 0) check("rr_grant", 32'(bus.o_GRANT_ID), (c / 5) % 4);
            check("rr_write", 32'(bus.o_FIFO_WRITE), 32'(prev_rdy != 0));
            if (prev_rdy != 0) check("rr_data", 32'(bus.o_FIFO_DATA), 32'h0A0 + prev_gnt);
            check("rr_level", 32'(bus.o_LEVEL), exp_level);
            if (exp_rdy != 0) exp_level++;
            prev_rdy = exp_rdy;
            prev_gnt = (c / 5) % 4;
            tick();
        end

        // ---------------- single requester 2, ten beats: bursts 4,4,2 ----------------
        do_reset();
        t2_mask   = 15'h3BDE;  // ready[2] expected in cycles 1-4, 6-9, 11-13
        exp_level = 0;
        for (int c = 0; c < 15; c++) begin
            bus.i_REQ_VALID = (c <= 12) ? 4'b0100 : 4'b0000;
            #1;
            check("solo_ready", 32'(bus.o_REQ_READY), t2_mask[c] ? 4 : 0);
            if (t2_mask[c]) check("solo_grant", 32'(bus.o_GRANT_ID), 2);
            check("solo_level", 32'(bus.o_LEVEL), exp_level);
            if (t2_mask[c] && c <= 12) exp_level++;
            tick();
        end
        #1;
        check("solo_level_end", 32'(bus.o_LEVEL), 10);
        check("solo_full_end",  32'(bus.o_FULL), 0);

        // ---------------- CAP=7: fill, stall, one read frees exactly one slot ----------------
        do_reset();
        bus_s.i_REQ_VALID = 4'b0001;
        repeat (12) tick();
        #1;
        check("full_level", 32'(bus_s.o_LEVEL), 7);
        check("full_flag",  32'(bus_s.o_FULL), 1);
        check("full_ready", 32'(bus_s.o_REQ_READY), 0);
        check("full_write", 32'(bus_s.o_FIFO_WRITE), 0);
        bus_s.i_FIFO_READ = 1'b1;
        #1;
        check("full_rd_ready", 32'(bus_s.o_REQ_READY), 0);
        tick();
        bus_s.i_FIFO_READ = 1'b0;
        #1;
        check("after_rd_level", 32'(bus_s.o_LEVEL), 6);
        check("after_rd_full",  32'(bus_s.o_FULL), 0);
        check("after_rd_ready", 32'(bus_s.o_REQ_READY), 1);
        tick();
        #1;
        check("refill_write", 32'(bus_s.o_FIFO_WRITE), 1);
        check("refill_data",  32'(bus_s.o_FIFO_DATA), 32'h0B0);
        check("refill_level", 32'(bus_s.o_LEVEL), 7);
        check("refill_full",  32'(bus_s.o_FULL), 1);
        check("refill_ready", 32'(bus_s.o_REQ_READY), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("hold_write", 32'(bus_s.o_FIFO_WRITE), 0);
            check("hold_level", 32'(bus_s.o_LEVEL), 7);
        end

        // ---------------- accept and read together at level 3 ----------------
        do_reset();
        bus.i_REQ_DATA[15:8] = 8'h5C;
        bus.i_REQ_VALID      = 4'b0010;
        repeat (4) tick();
        #1;
        check("both_pre_level", 32'(bus.o_LEVEL), 3);
        check("both_pre_ready", 32'(bus.o_REQ_READY), 2);
        bus.i_FIFO_READ = 1'b1;
        tick();
        bus.i_FIFO_READ = 1'b0;
        bus.i_REQ_VALID = 4'b0000;
        #1;
        check("both_level", 32'(bus.o_LEVEL), 3);
        check("both_write", 32'(bus.o_FIFO_WRITE), 1);
        check("both_data",  32'(bus.o_FIFO_DATA), 32'h05C);
        tick();
        #1;
        check("both_write_end", 32'(bus.o_FIFO_WRITE), 0);
        check("both_level_end", 32'(bus.o_LEVEL), 3);

        // ---------------- read while empty ----------------
        do_reset();
        bus.i_FIFO_READ = 1'b1;
        #1;
        check("uf_level_pre", 32'(bus.o_LEVEL), 0);
`ifdef SFIFO_ARB_ERR_EN
        check("uf_err_pre", 32'(bus.o_ERR), 0);
`endif
        tick();
        bus.i_FIFO_READ = 1'b0;
        #1;
        check("uf_level", 32'(bus.o_LEVEL), 0);
        check("uf_full",  32'(bus.o_FULL), 0);
`ifdef SFIFO_ARB_ERR_EN
        check("uf_err", 32'(bus.o_ERR), 1);
        tick();
        tick();
        #1;
        check("uf_err_sticky", 32'(bus.o_ERR), 1);
        do_reset();
        #1;
        check("uf_err_cleared", 32'(bus.o_ERR), 0);
`endif

        // ---------------- asynchronous reset mid-burst ----------------
        do_reset();
        bus.i_REQ_VALID = 4'hF;
        repeat (3) tick();
        #1;
        check("mid_pre_write", 32'(bus.o_FIFO_WRITE), 1);
        check("mid_pre_level", 32'(bus.o_LEVEL), 2);
        check("mid_pre_ready", 32'(bus.o_REQ_READY), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.o_REQ_READY), 0);
        check("mid_rst_write", 32'(bus.o_FIFO_WRITE), 0);
        check("mid_rst_level", 32'(bus.o_LEVEL), 0);
        check("mid_rst_full",  32'(bus.o_FULL), 0);
        check("mid_rst_grant", 32'(bus.o_GRANT_ID), 3);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(bus.o_REQ_READY), 0);
        tick();
        #1;
        check("mid_first_ready", 32'(bus.o_REQ_READY), 1);
        check("mid_first_grant", 32'(bus.o_GRANT_ID), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/sfifo_write_arbiter.md
Name: sfifo_write_arbiter

Overview:
Shares the single write port of the team's sync FIFO (2**p_FIFO_DEPTH entries, 2**p_FIFO_DEPTH-1 usable) between p_NUM_REQ producers. It uses round-robin arbitration with bounded bursts and a per-requester valid/ready handshake. The block keeps its own occupancy counter from accepted writes and the FIFO read strobe, so it never writes a full FIFO and never depends on the FIFO's registered, lagging flags. It sits directly in front of the FIFO: its write strobe and data drive the FIFO write port, and the consumer's read strobe is tapped into i_FIFO_READ.

Parameters:
p_NUM_REQ, 4, number of requesters (2..16)
p_DATA_WIDTH, 8, data width per requester and to the FIFO
p_FIFO_DEPTH, 8, log2 of the FIFO entry count; usable capacity CAP = 2**p_FIFO_DEPTH-1
p_MAX_BURST, 4, maximum beats accepted per grant before rotating (>=1)

Ports:
i_CLK  in  1  clock, rising edge
i_RESET  in  1  reset, asynchronous, active-high
i_REQ_VALID  in  p_NUM_REQ  per-requester data valid
i_REQ_DATA  in  p_NUM_REQ*p_DATA_WIDTH  requester k data at bits [k*W +: W]
o_REQ_READY  out  p_NUM_REQ  per-requester ready; one-hot or zero
i_FIFO_READ  in  1  read strobe presented to the FIFO this cycle
o_FIFO_WRITE  out  1  registered FIFO write strobe
o_FIFO_DATA  out  p_DATA_WIDTH  registered FIFO write data
o_LEVEL  out  p_FIFO_DEPTH+1  registered occupancy (accepted writes minus reads)
o_FULL  out  1  registered, o_LEVEL == CAP
o_GRANT_ID  out  clog2(p_NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - o_FIFO_WRITE=0, o_FIFO_DATA=0, o_LEVEL=0, o_FULL=0.
  - o_GRANT_ID = p_NUM_REQ-1, so requester 0 wins first; burst count 0.
  - A reset mid-burst drops any pending write beat. The FIFO must be reset together with this block.
- Transfer: a beat transfers when i_REQ_VALID[k] & o_REQ_READY[k]. In the next cycle o_FIFO_WRITE=1 and o_FIFO_DATA carries that beat (latency 1).
- o_REQ_READY[k] is combinational. It is 1 only when state=BURST, k=o_GRANT_ID, and o_LEVEL < CAP.
- States:
  - IDLE: if any valid, pick the first valid index strictly after o_GRANT_ID (modulo p_NUM_REQ). Register it into o_GRANT_ID, clear the burst count, go to BURST. If none is valid, stay in IDLE. This costs one arbitration bubble per grant.
  - BURST: each transfer increments the burst count. Go to IDLE when the count reaches p_MAX_BURST, or when the granted valid is low. A full stall (ready=0 with valid=1) keeps BURST with no timeout.
- Level (CAP+1 states, no wrap):
  - Accept and no read: +1.
  - Read and no accept: -1.
  - Both, or neither: unchanged.
  - A read while o_LEVEL==0 is ignored; the level stays 0.
  - The level never exceeds CAP, because ready is gated.
- o_FULL is registered from the next-state level (o_FULL == (o_LEVEL==CAP) in every cycle).
- Only the granted requester ever sees ready. Non-granted data is ignored.

Optional Feature:
SFIFO_ARB_ERR_EN:
- Defined: adds output o_ERR (1 bit, reset 0). It is sticky-set the cycle after i_FIFO_READ=1 with o_LEVEL==0, and cleared only by reset.
- Undefined: no port; the underflow read is silently ignored.

Decomposition:
- Package sfifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a CAP calculation function from p_FIFO_DEPTH;
  - a clog2 helper for the o_GRANT_ID width.
- Sub-module rr_priority_pick: combinational round-robin picker. Inputs are a request vector and the last index; outputs are a found flag and the next index. It is instantiated once.

Test Plan:
- Reset, then all four valid held high (p_MAX_BURST=4): grants in order 0,1,2,3,0. Each burst is 4 beats, separated by 1 IDLE bubble, and o_FIFO_DATA matches the source order.
- Only requester 2 valid, for 10 beats: bursts of 4, 4, 2, and requester 2 is re-granted after each bubble. o_LEVEL goes 0→10 with no reads.
- With p_FIFO_DEPTH=3 (CAP=7), write 7 with no reads: o_FULL=1 and ready=0 while valid is held. One i_FIFO_READ pulse gives o_LEVEL=6, then exactly one more beat is accepted and o_LEVEL returns to 7.
- Simultaneous accept and i_FIFO_READ at o_LEVEL=3: o_LEVEL stays 3 and o_FIFO_WRITE pulses the next cycle.
- i_FIFO_READ at o_LEVEL=0: o_LEVEL stays 0. With SFIFO_ARB_ERR_EN, o_ERR=1 from the next cycle until reset.
- Assert i_RESET mid-burst, asynchronously between edges: ready, o_FIFO_WRITE, o_LEVEL and o_FULL go to 0 immediately. After release, requester 0 is granted first.
